// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: req/ack data-memory access with lane steering, load extension and stall.
// Optional bus timeout is compiled in with MEMACC_TIMEOUT_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        Reset_in,
    input  logic        valid_in,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic [1:0]  size_in,
    input  logic        signExt_in,
    input  logic [31:0] aluOut_in,
    input  logic [31:0] storeData_in,
    input  logic [4:0]  regWriteAddress_in,
    input  logic        regShouldWrite_in,
    input  logic        memToReg_in,
    input  logic        isRtype_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] memReadData_out,
    output logic [31:0] aluOut_out,
    output logic [4:0]  regWriteAddress_out,
    output logic        memToReg_out,
    output logic        isRtype_out,
    output logic        regShouldWrite_out,
    output logic        misalign_err_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic        memOp, aligned, access;
    logic [3:0]  wrBe;
    logic [31:0] wrData;
    logic [1:0]  rdOff, rdSize;
    logic        rdSign, rdLoad;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    logic [31:0] loadExt;

    assign memOp  = memRead_in | memWrite_in;
    assign access = valid_in & memOp & aligned;

    always_comb begin
        case (size_in)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~aluOut_in[0];
            default: aligned = (aluOut_in[1:0] == 2'b00);
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        wrBe   = 4'b1111;
        wrData = storeData_in;
        case (size_in)
            2'b00: begin
                wrBe   = 4'b0001 << aluOut_in[1:0];
                wrData = {4{storeData_in[7:0]}};
            end
            2'b01: begin
                wrBe   = aluOut_in[1] ? 4'b1100 : 4'b0011;
                wrData = {2{storeData_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (rdOff)
            2'b00:   lane8 = dmem_rdata[7:0];
            2'b01:   lane8 = dmem_rdata[15:8];
            2'b10:   lane8 = dmem_rdata[23:16];
            default: lane8 = dmem_rdata[31:24];
        endcase
        lane16 = rdOff[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (rdSize)
            2'b00:   loadExt = {{24{rdSign & lane8[7]}}, lane8};
            2'b01:   loadExt = {{16{rdSign & lane16[15]}}, lane16};
            default: loadExt = dmem_rdata;
        endcase
    end

`ifdef MEMACC_TIMEOUT_EN
    logic [7:0] waitCnt;
`else
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset_in) begin
        if (!Reset_in) begin
            state           <= IDLE;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_be         <= 4'b0000;
            dmem_addr       <= 32'h0;
            dmem_wdata      <= 32'h0;
            memReadData_out <= 32'h0;
            rdOff           <= 2'b00;
            rdSize          <= 2'b00;
            rdSign          <= 1'b0;
            rdLoad          <= 1'b0;
`ifdef MEMACC_TIMEOUT_EN
            waitCnt         <= 8'h00;
            bus_err_out     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= memWrite_in;
                        dmem_be    <= wrBe;
                        dmem_addr  <= {aluOut_in[31:2], 2'b00};
                        dmem_wdata <= wrData;
                        rdOff      <= aluOut_in[1:0];
                        rdSize     <= size_in;
                        rdSign     <= signExt_in;
                        rdLoad     <= memRead_in;
`ifdef MEMACC_TIMEOUT_EN
                        waitCnt    <= 8'h00;
`endif
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= 4'b0000;
                        if (rdLoad)
                            memReadData_out <= loadExt;
                        state    <= DONE;
                    end
`ifdef MEMACC_TIMEOUT_EN
                    else if (waitCnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        dmem_req        <= 1'b0;
                        dmem_we         <= 1'b0;
                        dmem_be         <= 4'b0000;
                        memReadData_out <= 32'h0;
                        bus_err_out     <= 1'b1;
                        state           <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 8'h01;
                    end
`endif
                end
                default: begin
`ifdef MEMACC_TIMEOUT_EN
                    bus_err_out <= 1'b0;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall_out        = ((state == IDLE) & access) | (state == WAIT);
    assign misalign_err_out = valid_in & memOp & ~aligned;

    // A timed-out access reaches DONE with bus_err_out high, which suppresses the write-back.
    assign regShouldWrite_out  = regShouldWrite_in & ~stall_out & ~misalign_err_out & ~bus_err_out;
    assign aluOut_out          = aluOut_in;
    assign regWriteAddress_out = regWriteAddress_in;
    assign memToReg_out        = memToReg_in;
    assign isRtype_out         = isRtype_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        Reset_in;
    logic        valid_in, memRead_in, memWrite_in, signExt_in;
    logic [1:0]  size_in;
    logic [31:0] aluOut_in, storeData_in;
    logic [4:0]  regWriteAddress_in;
    logic        regShouldWrite_in, memToReg_in, isRtype_in;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic [31:0] memReadData_out, aluOut_out;
    logic [4:0]  regWriteAddress_out;
    logic        memToReg_out, isRtype_out, regShouldWrite_out, misalign_err_out, bus_err_out;

    int nAsserts = 0;
    int nFail    = 0;
    int stalls;

    always #5 CLK = ~CLK;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .Reset_in(Reset_in), .valid_in(valid_in), .memRead_in(memRead_in),
        .memWrite_in(memWrite_in), .size_in(size_in), .signExt_in(signExt_in),
        .aluOut_in(aluOut_in), .storeData_in(storeData_in),
        .regWriteAddress_in(regWriteAddress_in), .regShouldWrite_in(regShouldWrite_in),
        .memToReg_in(memToReg_in), .isRtype_in(isRtype_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .memReadData_out(memReadData_out), .aluOut_out(aluOut_out),
        .regWriteAddress_out(regWriteAddress_out), .memToReg_out(memToReg_out),
        .isRtype_out(isRtype_out), .regShouldWrite_out(regShouldWrite_out),
        .misalign_err_out(misalign_err_out), .bus_err_out(bus_err_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setInstr(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic [31:0] addr, input logic [31:0] sd,
                            input logic rsw);
        valid_in = v; memRead_in = rd; memWrite_in = wr; size_in = sz; signExt_in = sx;
        aluOut_in = addr; storeData_in = sd; regShouldWrite_in = rsw;
    endtask

    // Called at a negedge with the instruction applied; returns #1 into the first unstalled cycle.
    task automatic busTxn(input int ackCycle, input logic [31:0] rdata, output int nStall);
        nStall = 0;
        for (int k = 0; k < 40; k++) begin
            dmem_ack   = (k == ackCycle);
            dmem_rdata = (k == ackCycle) ? rdata : 32'hDEAD_BEEF;
            #1;
            if (!stall_out) break;
            nStall++;
            @(negedge CLK);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic nextCycle();
        @(negedge CLK);
        setInstr(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
    endtask

    initial begin
        Reset_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        regWriteAddress_in = 5'd5; memToReg_in = 1'b1; isRtype_in = 1'b0;
        setInstr(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_be", {28'b0, dmem_be}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_rdata", memReadData_out, 32'h0);
        chk("rst_buserr", {31'b0, bus_err_out}, 32'h0);
        @(negedge CLK);
        Reset_in = 1'b1;

        // LW 0x100, ack in third WAIT cycle
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        #1;
        chk("lw_rsw_idle", {31'b0, regShouldWrite_out}, 32'h0);
        @(negedge CLK); #1;
        chk("lw_req", {31'b0, dmem_req}, 32'h1);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_be", {28'b0, dmem_be}, 32'hF);
        chk("lw_we", {31'b0, dmem_we}, 32'h0);
        chk("lw_rsw_wait", {31'b0, regShouldWrite_out}, 32'h0);
        busTxn(2, 32'h89AB_CDEF, stalls);
        chk("lw_stalls", 32'(stalls + 1), 32'd4);
        chk("lw_data", memReadData_out, 32'h89AB_CDEF);
        chk("lw_rsw_done", {31'b0, regShouldWrite_out}, 32'h1);
        chk("lw_req_done", {31'b0, dmem_req}, 32'h0);
        chk("lw_buserr", {31'b0, bus_err_out}, 32'h0);

        // LB signed / LBU / LH signed, ack in first WAIT cycle
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1);
        busTxn(1, 32'h80FF_FF7F, stalls);
        chk("lb_stalls", 32'(stalls), 32'd2);
        chk("lb_data", memReadData_out, 32'hFFFF_FF80);
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1);
        busTxn(1, 32'h80FF_FF7F, stalls);
        chk("lbu_data", memReadData_out, 32'h0000_0080);
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1);
        busTxn(1, 32'h8001_0000, stalls);
        chk("lh_data", memReadData_out, 32'hFFFF_8001);

        // SH 0x206
        @(negedge CLK);
        setInstr(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h206, 32'h0000_BEEF, 1'b0);
        #1;
        chk("sh_stall_idle", {31'b0, stall_out}, 32'h1);
        @(negedge CLK); #1;
        chk("sh_we", {31'b0, dmem_we}, 32'h1);
        chk("sh_be", {28'b0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr, 32'h204);
        dmem_ack = 1'b1;
        @(negedge CLK); dmem_ack = 1'b0; #1;
        chk("sh_done_stall", {31'b0, stall_out}, 32'h0);
        chk("sh_done_req", {31'b0, dmem_req}, 32'h0);
        chk("lh_data_kept", memReadData_out, 32'hFFFF_8001);

        // SB 0x201
        @(negedge CLK);
        setInstr(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h1234_5678, 1'b0);
        @(negedge CLK); #1;
        chk("sb_be", {28'b0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h7878_7878);
        busTxn(0 + 1, 32'h0, stalls);
        chk("sb_done", {31'b0, stall_out}, 32'h0);

        // Misaligned LW 0x102
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1);
        #1;
        chk("mis_err", {31'b0, misalign_err_out}, 32'h1);
        chk("mis_stall", {31'b0, stall_out}, 32'h0);
        chk("mis_rsw", {31'b0, regShouldWrite_out}, 32'h0);
        nextCycle();
        chk("mis_err_clr", {31'b0, misalign_err_out}, 32'h0);
        chk("mis_noreq", {31'b0, dmem_req}, 32'h0);

        // Ack while IDLE is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge CLK); dmem_ack = 1'b0; #1;
        chk("idle_ack_req", {31'b0, dmem_req}, 32'h0);
        chk("idle_ack_data", memReadData_out, 32'hFFFF_8001);

        // Non-memory instruction passes through
        @(negedge CLK);
        setInstr(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 1'b1);
        regWriteAddress_in = 5'd7; isRtype_in = 1'b1;
        #1;
        chk("alu_stall", {31'b0, stall_out}, 32'h0);
        chk("alu_rsw", {31'b0, regShouldWrite_out}, 32'h1);
        chk("alu_out", aluOut_out, 32'h55);
        chk("alu_rd", {27'b0, regWriteAddress_out}, 32'd7);
        chk("alu_rtype", {31'b0, isRtype_out}, 32'h1);

        // Reset during WAIT
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
        @(negedge CLK); #1;
        chk("rst_mid_req", {31'b0, dmem_req}, 32'h1);
        #2; Reset_in = 1'b0; #1;
        chk("rst_mid_drop", {31'b0, dmem_req}, 32'h0);
        chk("rst_mid_data", memReadData_out, 32'h0);
        nextCycle();
        Reset_in = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
        @(negedge CLK); dmem_ack = 1'b0; #1;
        chk("late_ack_req", {31'b0, dmem_req}, 32'h0);
        chk("late_ack_data", memReadData_out, 32'h0);
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 1'b1);
        busTxn(2, 32'h1122_3344, stalls);
        chk("post_rst_stalls", 32'(stalls), 32'd3);
        chk("post_rst_data", memReadData_out, 32'h1122_3344);

`ifdef MEMACC_TIMEOUT_EN
        // No ack: timeout after 4 WAIT cycles
        @(negedge CLK);
        setInstr(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 1'b1);
        busTxn(1000, 32'h0, stalls);
        chk("to_stalls", 32'(stalls), 32'd5);
        chk("to_buserr", {31'b0, bus_err_out}, 32'h1);
        chk("to_data", memReadData_out, 32'h0);
        chk("to_rsw", {31'b0, regShouldWrite_out}, 32'h0);
        chk("to_req", {31'b0, dmem_req}, 32'h0);
        nextCycle();
        chk("to_buserr_clr", {31'b0, bus_err_out}, 32'h0);
`endif

        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
